// File: rtl/touch_pad_decoder.sv
// touch_pad_decoder
//   Turns one raw, pulled-up touch pad input into clean debounced events.
//   The pad is resynchronised, debounced with a consecutive-sample counter,
//   and a small hold FSM classifies each press as a click or a long press.
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   pad_n         in   raw pad level, asynchronous (0 = touched)
//   pressed       out  debounced level, 1 while touched
//   press_pulse   out  one-cycle strobe on the debounced press
//   release_pulse out  one-cycle strobe on the debounced release
//   click_pulse   out  one-cycle strobe on a release before the long threshold
//   long_pulse    out  one-cycle strobe when the hold reaches LONG_CYCLES
//
// FSM states
//   state        | meaning
//   ST_IDLE      | pad released, waiting for a debounced press
//   ST_PRESSED   | pad held, hold counter running toward the long threshold
//   ST_LONG_HELD | long press already reported, waiting for release
module touch_pad_decoder #(
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int LONG_CYCLES     = 48000000
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int LW = $clog2(LONG_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } state_e;

  logic          s1_q, s2_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          db_state_q, db_state_d;
  logic [LW-1:0] hold_q, hold_d;
  state_e        state_q, state_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          click_q, click_d;
  logic          long_q, long_d;

  logic          active;
  logic          rise, fall;

  assign active = ~s2_q;

  // Debounce: the state flips only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  // rise/fall mark the edge on which the flip happens, so the FSM strobes
  // land in the same cycle that pressed changes.
  always_comb begin
    db_cnt_d   = '0;
    db_state_d = db_state_q;
    rise       = 1'b0;
    fall       = 1'b0;
    if (active != db_state_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_state_d = active;
        rise       = active;
        fall       = ~active;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_PRESSED;
          hold_d  = '0;
          press_d = 1'b1;
        end
      end
      ST_PRESSED: begin
        // A release on the threshold edge is still a click.
        if (fall) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          click_d   = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_LONG_HELD;
          long_d  = 1'b1;
        end else begin
          hold_d = hold_q + LW'(1);
        end
      end
      ST_LONG_HELD: begin
        if (fall) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      db_cnt_q   <= '0;
      db_state_q <= 1'b0;
      hold_q     <= '0;
      state_q    <= ST_IDLE;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      click_q    <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      s1_q       <= pad_n;
      s2_q       <= s1_q;
      db_cnt_q   <= db_cnt_d;
      db_state_q <= db_state_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
      press_q    <= press_d;
      release_q  <= release_d;
      click_q    <= click_d;
      long_q     <= long_d;
    end
  end

  assign pressed       = db_state_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign click_pulse   = click_q;
  assign long_pulse    = long_q;

endmodule

// File: tb/tb_touch_pad_decoder.sv
module tb_touch_pad_decoder;

  localparam int D = 4;
  localparam int L = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pad_n = 1'b1;
  logic pressed, press_pulse, release_pulse, click_pulse, long_pulse;

  touch_pad_decoder #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk), .rst(rst), .pad_n(pad_n),
    .pressed(pressed), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .click_pulse(click_pulse),
    .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: pad sample history, a sliding window of the last D
  // synchronized "touched" samples, and press bookkeeping by edge number.
  bit samp[$];
  bit win[$];
  bit m_state   = 1'b0;
  bit long_done = 1'b0;
  int p_edge    = 0;
  bit e_press, e_release, e_click, e_long;

  // Observed strobe history for the directed scenarios.
  int base, n_press, n_release, n_click, n_long;
  int last_press, last_release, last_click, last_long;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model(input logic r, input logic p);
    bit act, flip;
    e_press = 0; e_release = 0; e_click = 0; e_long = 0;
    if (r) begin
      samp.delete(); samp.push_back(1'b1); samp.push_back(1'b1);
      win.delete();
      m_state = 0; long_done = 0; p_edge = 0;
    end else begin
      act = ~samp[samp.size()-2];
      samp.push_back(p);
      if (samp.size() > 4) void'(samp.pop_front());
      win.push_back(act);
      if (win.size() > D) void'(win.pop_front());
      flip = (win.size() == D);
      foreach (win[i]) if (win[i] == m_state) flip = 0;
      if (flip) begin
        m_state = act;
        if (act) begin
          e_press = 1; p_edge = cyc; long_done = 0;
        end else begin
          e_release = 1; e_click = !long_done;
        end
      end else if (m_state && !long_done && (cyc - p_edge) == L) begin
        e_long = 1; long_done = 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic p);
    rst = r; pad_n = p;
    @(posedge clk);
    cyc++;
    model(r, p);
    #1;
    check("pressed", pressed, m_state);
    check("press_pulse", press_pulse, e_press);
    check("release_pulse", release_pulse, e_release);
    check("click_pulse", click_pulse, e_click);
    check("long_pulse", long_pulse, e_long);
    if (press_pulse === 1'b1)   begin n_press++;   last_press = cyc;   end
    if (release_pulse === 1'b1) begin n_release++; last_release = cyc; end
    if (click_pulse === 1'b1)   begin n_click++;   last_click = cyc;   end
    if (long_pulse === 1'b1)    begin n_long++;    last_long = cyc;    end
  endtask

  task automatic run(input int n, input logic p);
    for (int i = 0; i < n; i++) step(1'b0, p);
  endtask

  task automatic begin_test();
    base = cyc;
    n_press = 0; n_release = 0; n_click = 0; n_long = 0;
    last_press = -1; last_release = -1; last_click = -1; last_long = -1;
  endtask

  initial begin
    // 1: reset and idle
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    begin_test();
    run(50, 1'b1);
    check("t1_no_press", n_press, 0);

    // 2: short click
    begin_test();
    run(15, 1'b0);
    run(20, 1'b1);
    check("t2_press_edge", last_press - base, 6);
    check("t2_press_count", n_press, 1);
    check("t2_release_edge", last_release - base, 21);
    check("t2_click_edge", last_click - base, 21);
    check("t2_long_count", n_long, 0);

    // 3: glitches while released, then bounce while pressed
    begin_test();
    run(3, 1'b0);
    run(10, 1'b1);
    for (int i = 0; i < 20; i++) run(2, i[0]);
    run(10, 1'b1);
    check("t3_glitch_press", n_press, 0);
    run(8, 1'b0);
    check("t3_pressed", pressed, 1);
    begin_test();
    run(3, 1'b1);
    run(1, 1'b0);
    for (int i = 0; i < 4; i++) run(2, ~i[0]);
    check("t3_bounce_release", n_release, 0);
    check("t3_still_pressed", pressed, 1);
    run(30, 1'b1);

    // 4: long press
    begin_test();
    run(40, 1'b0);
    run(15, 1'b1);
    check("t4_press_edge", last_press - base, 6);
    check("t4_long_edge", last_long - base, 26);
    check("t4_long_count", n_long, 1);
    check("t4_release_edge", last_release - base, 46);
    check("t4_click_count", n_click, 0);

    // 5: debounced fall lands on the long-threshold edge
    begin_test();
    run(20, 1'b0);
    run(15, 1'b1);
    check("t5_release_edge", last_release - base, 26);
    check("t5_click_edge", last_click - base, 26);
    check("t5_long_count", n_long, 0);
    run(30, 1'b0);
    check("t5_back_idle_long", last_long - base, 61);
    run(10, 1'b1);

    // 6: reset while pressed, pad kept low
    begin_test();
    run(9, 1'b0);
    step(1'b1, 1'b0);
    run(10, 1'b0);
    check("t6_press_count", n_press, 2);
    check("t6_repress_edge", last_press - base, 16);
    check("t6_release_count", n_release, 0);
    run(10, 1'b1);

    // Randomized runs with occasional reset
    for (int k = 0; k < 80; k++) begin
      int len;
      logic lvl;
      lvl = logic'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(18, 35) : $urandom_range(1, 10);
      if ($urandom_range(0, 19) == 0) step(1'b1, lvl);
      run(len, lvl);
    end
    run(10, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
